// File: rtl/watch_time_base.sv
// Watch time base: divides clk into one-cycle second/minute/hour strobes and a
// 50% blink level, with fast-minute mode, hold and synchronous counter clear.
module watch_time_base #(
    parameter int unsigned TICKS_PER_SEC     = 256,
    parameter int unsigned SECS_PER_MIN      = 60,
    parameter int unsigned FAST_SECS_PER_MIN = 1,
    parameter int unsigned MINS_PER_HOUR     = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic reset_count,
    input  logic fast_watch,
    input  logic hold,
    output logic one_second,
    output logic one_minute,
    output logic one_hour,
    output logic blink
);

    localparam int unsigned TickW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned SecW  = (SECS_PER_MIN > 1)  ? $clog2(SECS_PER_MIN)  : 1;
    localparam int unsigned MinW  = (MINS_PER_HOUR > 1) ? $clog2(MINS_PER_HOUR) : 1;

    localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_SEC - 1);
    localparam logic [TickW-1:0] TickHalf = TickW'(TICKS_PER_SEC / 2);
    localparam logic [SecW-1:0]  SecLast  = SecW'(SECS_PER_MIN - 1);
    localparam logic [SecW-1:0]  FastLast = SecW'(FAST_SECS_PER_MIN - 1);
    localparam logic [MinW-1:0]  MinLast  = MinW'(MINS_PER_HOUR - 1);

    logic [TickW-1:0] tick_q, tick_d;
    logic [SecW-1:0]  sec_q, sec_d;
    logic [MinW-1:0]  min_q, min_d;
    logic             sec_stb_q, sec_stb_d;
    logic             min_stb_q, min_stb_d;
    logic             hour_stb_q, hour_stb_d;
    logic [SecW-1:0]  sec_last;

    always_comb begin
        tick_d     = tick_q;
        sec_d      = sec_q;
        min_d      = min_q;
        sec_stb_d  = 1'b0;
        min_stb_d  = 1'b0;
        hour_stb_d = 1'b0;
        sec_last   = fast_watch ? FastLast : SecLast;

        if (reset_count) begin
            tick_d = '0;
            sec_d  = '0;
            min_d  = '0;
        end else if (!hold) begin
            if (tick_q == TickLast) begin
                tick_d    = '0;
                sec_stb_d = 1'b1;
                // ">=" lets a shortened minute wrap even if sec_q is already past it
                if (sec_q >= sec_last) begin
                    sec_d     = '0;
                    min_stb_d = 1'b1;
                    if (min_q == MinLast) begin
                        min_d      = '0;
                        hour_stb_d = 1'b1;
                    end else begin
                        min_d = min_q + 1'b1;
                    end
                end else begin
                    sec_d = sec_q + 1'b1;
                end
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q     <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            sec_stb_q  <= 1'b0;
            min_stb_q  <= 1'b0;
            hour_stb_q <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            sec_stb_q  <= sec_stb_d;
            min_stb_q  <= min_stb_d;
            hour_stb_q <= hour_stb_d;
        end
    end

    assign one_second = sec_stb_q;
    assign one_minute = min_stb_q;
    assign one_hour   = hour_stb_q;
    assign blink      = (tick_q < TickHalf);

endmodule

// File: tb/tb_watch_time_base.sv
// Bench for watch_time_base: three instances (4/3/1/2, 4/5/1/2, defaults) checked
// every cycle against an elapsed-time model plus directed literal expectations.
module tb_watch_time_base;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst, rc, fw, hd;
    logic [2:0] os, om, oh, bl;

    int checks = 0;
    int errors = 0;

    watch_time_base #(
        .TICKS_PER_SEC(4), .SECS_PER_MIN(3), .FAST_SECS_PER_MIN(1), .MINS_PER_HOUR(2)
    ) dut_a (
        .clk(clk), .reset(rst[0]), .reset_count(rc[0]), .fast_watch(fw[0]), .hold(hd[0]),
        .one_second(os[0]), .one_minute(om[0]), .one_hour(oh[0]), .blink(bl[0])
    );

    watch_time_base #(
        .TICKS_PER_SEC(4), .SECS_PER_MIN(5), .FAST_SECS_PER_MIN(1), .MINS_PER_HOUR(2)
    ) dut_b (
        .clk(clk), .reset(rst[1]), .reset_count(rc[1]), .fast_watch(fw[1]), .hold(hd[1]),
        .one_second(os[1]), .one_minute(om[1]), .one_hour(oh[1]), .blink(bl[1])
    );

    watch_time_base dut_c (
        .clk(clk), .reset(rst[2]), .reset_count(rc[2]), .fast_watch(fw[2]), .hold(hd[2]),
        .one_second(os[2]), .one_minute(om[2]), .one_hour(oh[2]), .blink(bl[2])
    );

    function automatic int p_t(int i);
        return (i == 2) ? 256 : 4;
    endfunction
    function automatic int p_s(int i);
        return (i == 0) ? 3 : ((i == 1) ? 5 : 60);
    endfunction
    function automatic int p_h(int i);
        return (i == 2) ? 60 : 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edges elapsed in the current second, seconds into minute, minutes into hour
    int ph[3], sc[3], mn[3];
    bit es[3], em[3], eh[3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            ph[i] = 0; sc[i] = 0; mn[i] = 0; es[i] = 0; em[i] = 0; eh[i] = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                es[i] = 0; em[i] = 0; eh[i] = 0;
                if (rst[i] || rc[i]) begin
                    ph[i] = 0; sc[i] = 0; mn[i] = 0;
                end else if (!hd[i]) begin
                    ph[i]++;
                    if (ph[i] == p_t(i)) begin
                        ph[i] = 0;
                        es[i] = 1;
                        sc[i]++;
                        if (sc[i] >= (fw[i] ? 1 : p_s(i))) begin
                            sc[i] = 0;
                            em[i] = 1;
                            mn[i]++;
                            if (mn[i] == p_h(i)) begin
                                mn[i] = 0;
                                eh[i] = 1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model, plus width and nesting rules
    initial begin
        logic [2:0] pos, pom, poh;
        pos = '0; pom = '0; poh = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("one_second[%0d]", i), os[i], es[i]);
                chk($sformatf("one_minute[%0d]", i), om[i], em[i]);
                chk($sformatf("one_hour[%0d]", i), oh[i], eh[i]);
                chk($sformatf("blink[%0d]", i), bl[i], ph[i] < p_t(i) / 2);
                chk($sformatf("sec_width[%0d]", i), os[i] && pos[i], 0);
                chk($sformatf("min_width[%0d]", i), om[i] && pom[i], 0);
                chk($sformatf("hour_width[%0d]", i), oh[i] && poh[i], 0);
                chk($sformatf("min_nest[%0d]", i), om[i] && !os[i], 0);
                chk($sformatf("hour_nest[%0d]", i), oh[i] && !om[i], 0);
            end
            pos = os; pom = om; poh = oh;
        end
    end

    initial begin
        int found;
        int gap;
        rst = 3'b111; rc = '0; fw = 3'b100; hd = '0;
        repeat (2) @(negedge clk);
        chk("rst_blink", bl[0], 1);
        chk("rst_sec", os[0], 0);
        rst = '0;

        // Free run on 4/3/1/2
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            chk("t1_sec", os[0], (k % 4) == 0);
            chk("t1_min", om[0], (k % 12) == 0);
            chk("t1_hour", oh[0], k == 24);
            chk("t1_blink", bl[0], (k % 4) < 2);
        end

        // Hold at tick 2
        repeat (3) @(negedge clk);
        hd[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            chk("t3_hold_blink", bl[0], 0);
            chk("t3_hold_sec", os[0], 0);
        end
        @(negedge clk);
        hd[0] = 1'b0;
        @(posedge clk); #1;
        chk("t3_rel1", os[0], 0);
        @(posedge clk); #1;
        chk("t3_rel2", os[0], 1);

        // reset_count at tick 3, sec 2 (would otherwise strobe second and minute)
        repeat (4) @(negedge clk);
        rc[0] = 1'b1;
        @(posedge clk); #1;
        chk("t4_rc_sec", os[0], 0);
        chk("t4_rc_min", om[0], 0);
        chk("t4_rc_blink", bl[0], 1);
        @(negedge clk);
        rc[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            chk("t4_sec", os[0], (k % 4) == 0);
            chk("t4_min", om[0], k == 12);
            chk("t4_hour", oh[0], 0);
        end

        // 4/5/1/2: reach sec 3, switch to fast
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        repeat (12) @(negedge clk);
        fw[1] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk("t5_fast_sec", os[1], k == 4);
            chk("t5_fast_min", om[1], k == 4);
        end
        @(negedge clk);
        fw[1] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            chk("t5_norm_sec", os[1], (k % 4) == 0);
            chk("t5_norm_min", om[1], k == 20);
        end

        // reset and hold together at tick 3
        repeat (4) @(negedge clk);
        rst[1] = 1'b1;
        hd[1] = 1'b1;
        @(posedge clk); #1;
        chk("t6_blink", bl[1], 1);
        chk("t6_sec", os[1], 0);
        chk("t6_min", om[1], 0);
        @(negedge clk);
        rst[1] = 1'b0;
        hd[1] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk("t6_sec_after", os[1], k == 4);
        end

        // Defaults in fast mode: every second is also a minute, 256 apart
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            found = 0;
            gap = 0;
            for (int c = 1; c <= 300 && found == 0; c++) begin
                @(posedge clk); #1;
                if (os[2]) begin
                    found = 1;
                    gap = c;
                end
            end
            chk("t2_sec_seen", found, 1);
            chk("t2_fast_min", om[2], 1);
            if (n > 0) chk("t2_fast_gap", gap, 256);
        end
        @(negedge clk);
        fw[2] = 1'b0;
        found = 0;
        gap = 0;
        for (int c = 1; c <= 20000 && found == 0; c++) begin
            @(posedge clk); #1;
            if (om[2]) begin
                found = 1;
                gap = c;
            end
        end
        chk("t2_norm_seen", found, 1);
        chk("t2_norm_gap", gap, 15360);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
